// File: rtl/monitor_verdict_collector.sv
// Verdict collector: captures cycles with active monitor streams, timestamps them,
// buffers the records and serialises each as a header word plus one word per active stream.
module monitor_verdict_collector #(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [63:0]            output_0,
    input  logic [63:0]            output_1,
    input  logic [63:0]            output_2,
    input  logic                   output_0_aktv,
    input  logic                   output_1_aktv,
    input  logic                   output_2_aktv,
    output logic [63:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0]       FULL_LVL = LW'(DEPTH);
    localparam logic [TS_WIDTH-1:0] TS_ONE   = TS_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        VALUE  = 2'd2
    } state_t;

    function automatic logic [1:0] lowest_idx(input logic [2:0] m);
        if (m[0]) begin
            lowest_idx = 2'd0;
        end else if (m[1]) begin
            lowest_idx = 2'd1;
        end else begin
            lowest_idx = 2'd2;
        end
    endfunction

    function automatic logic [1:0] next_idx(input logic [2:0] m, input logic [1:0] i);
        if ((i == 2'd0) && m[1]) begin
            next_idx = 2'd1;
        end else begin
            next_idx = 2'd2;
        end
    endfunction

    function automatic logic is_last(input logic [2:0] m, input logic [1:0] i);
        case (i)
            2'd0:    is_last = (m[2:1] == 2'b00);
            2'd1:    is_last = ~m[2];
            default: is_last = 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] sel_value(input logic [63:0] a, input logic [63:0] b,
                                              input logic [63:0] c, input logic [1:0] i);
        case (i)
            2'd0:    sel_value = a;
            2'd1:    sel_value = b;
            default: sel_value = c;
        endcase
    endfunction

    logic [TS_WIDTH-1:0] ts_mem_q   [DEPTH];
    logic [2:0]          mask_mem_q [DEPTH];
    logic [63:0]         v0_mem_q   [DEPTH];
    logic [63:0]         v1_mem_q   [DEPTH];
    logic [63:0]         v2_mem_q   [DEPTH];

    logic [TS_WIDTH-1:0] ts_q;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q, level_d;
    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [63:0]         out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d, out_first_q, out_first_d, out_last_q, out_last_d;
    logic                overflow_q;
    logic [15:0]         drop_count_q;

    logic [2:0]          mask_s, cur_mask_s, nh_mask_s;
    logic [TS_WIDTH-1:0] nh_ts_s;
    logic                push_req_s, push_ok_s, drop_s, pop_s, hs_s, cur_last_s, bypass_s;
    logic [PW-1:0]       rd_ptr_d;

    assign mask_s     = {output_2_aktv, output_1_aktv, output_0_aktv};
    assign push_req_s = en && (mask_s != 3'b000);
    assign hs_s       = out_valid_q && out_ready;
    assign cur_mask_s = mask_mem_q[rd_ptr_q];
    assign cur_last_s = is_last(cur_mask_s, idx_q);
    assign pop_s      = (state_q == VALUE) && hs_s && cur_last_s;
    assign push_ok_s  = push_req_s && ((level_q != FULL_LVL) || pop_s);
    assign drop_s     = push_req_s && !push_ok_s;
    assign level_d    = level_q + LW'(push_ok_s) - LW'(pop_s);
    assign rd_ptr_d   = rd_ptr_q + PW'(pop_s);

    // The record that heads the FIFO after this edge may be the one being captured now.
    assign bypass_s  = (level_q == LW'(pop_s));
    assign nh_mask_s = bypass_s ? mask_s : mask_mem_q[rd_ptr_d];
    assign nh_ts_s   = bypass_s ? ts_q   : ts_mem_q[rd_ptr_d];

    // Drain FSM next state: header, then one word per set mask bit in ascending order.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (level_d != '0) begin
                    state_d = HEADER;
                end else begin
                    state_d = IDLE;
                end
            end
            HEADER: begin
                if (hs_s) begin
                    state_d = VALUE;
                    idx_d   = lowest_idx(cur_mask_s);
                end else begin
                    state_d = HEADER;
                end
            end
            VALUE: begin
                if (hs_s && cur_last_s) begin
                    state_d = (level_d != '0) ? HEADER : IDLE;
                    idx_d   = 2'd0;
                end else if (hs_s) begin
                    idx_d   = next_idx(cur_mask_s, idx_q);
                end else begin
                    state_d = VALUE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Output word for the next cycle, derived from the next state so outputs stay registered.
    always_comb begin
        out_valid_d = 1'b0;
        out_data_d  = 64'd0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        case (state_d)
            HEADER: begin
                out_valid_d = 1'b1;
                out_data_d  = 64'({nh_mask_s, nh_ts_s});
                out_first_d = 1'b1;
            end
            VALUE: begin
                out_valid_d = 1'b1;
                out_data_d  = sel_value(v0_mem_q[rd_ptr_q], v1_mem_q[rd_ptr_q],
                                        v2_mem_q[rd_ptr_q], idx_d);
                out_last_d  = is_last(cur_mask_s, idx_d);
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Record storage; contents are only meaningful between read and write pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            ts_mem_q[wr_ptr_q]   <= ts_q;
            mask_mem_q[wr_ptr_q] <= mask_s;
            v0_mem_q[wr_ptr_q]   <= output_0;
            v1_mem_q[wr_ptr_q]   <= output_1;
            v2_mem_q[wr_ptr_q]   <= output_2;
        end
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            state_q      <= IDLE;
            idx_q        <= 2'd0;
            out_data_q   <= 64'd0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= 16'd0;
        end else begin
            if (en) begin
                ts_q <= ts_q + TS_ONE;
            end
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (drop_s) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 16'hFFFF) begin
                    drop_count_q <= drop_count_q + 16'd1;
                end
            end
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_first  = out_first_q;
    assign out_last   = out_last_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_monitor_verdict_collector.sv
// Directed, table-driven bench for monitor_verdict_collector with hand-computed expectations.
module tb_monitor_verdict_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [63:0] output_0 = 64'd0, output_1 = 64'd0, output_2 = 64'd0;
    logic        output_0_aktv = 1'b0, output_1_aktv = 1'b0, output_2_aktv = 1'b0;
    logic [63:0] out_data;
    logic        out_valid, out_first, out_last, overflow;
    logic        out_ready = 1'b0;
    logic [15:0] drop_count;
    logic [3:0]  fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    monitor_verdict_collector #(.DEPTH(8), .TS_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .en(en),
        .output_0(output_0), .output_1(output_1), .output_2(output_2),
        .output_0_aktv(output_0_aktv), .output_1_aktv(output_1_aktv), .output_2_aktv(output_2_aktv),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last), .overflow(overflow),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [2:0]  act;
        logic [63:0] v0, v1, v2;
        logic        rdy;
        logic        ev;
        logic [63:0] ed;
        logic        ef, el;
        logic [3:0]  elv;
    } vec_t;

    vec_t vecs [23];

    function automatic logic [63:0] hdr(input logic [2:0] m, input logic [31:0] t);
        return {29'd0, m, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [2:0] a, input logic [63:0] x0,
                         input logic [63:0] x1, input logic [63:0] x2, input logic r);
        en = e;
        {output_2_aktv, output_1_aktv, output_0_aktv} = a;
        output_0 = x0;
        output_1 = x1;
        output_2 = x2;
        out_ready = r;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [63:0] d, input logic f, input logic l);
        chk({name, ".valid"}, 64'(out_valid), 64'd1);
        chk({name, ".data"},  out_data, d);
        chk({name, ".first"}, 64'(out_first), 64'(f));
        chk({name, ".last"},  64'(out_last), 64'(l));
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, ".valid"}, 64'(out_valid), 64'd0);
        chk({name, ".first"}, 64'(out_first), 64'd0);
        chk({name, ".last"},  64'(out_last), 64'd0);
        chk({name, ".data"},  out_data, 64'd0);
        chk({name, ".level"}, 64'(fifo_level), 64'd0);
        chk({name, ".ovf"},   64'(overflow), 64'd0);
        chk({name, ".drops"}, 64'(drop_count), 64'd0);
    endtask

    initial begin
        // Tests 1 and 2 plus back-to-back records and a pop/push bypass into an empty FIFO.
        for (int i = 0; i < 4; i++) vecs[i] = '{1'b1, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 3'b111, 64'd1, 64'd2, 64'd3, 1'b1, 1'b1, 64'h0000_0007_0000_0004, 1'b1, 1'b0, 4'd1};
        vecs[5]  = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd1, 1'b0, 1'b0, 4'd1};
        vecs[6]  = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd2, 1'b0, 1'b0, 4'd1};
        vecs[7]  = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd3, 1'b0, 1'b1, 4'd1};
        vecs[8]  = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0};
        vecs[9]  = '{1'b1, 3'b101, 64'hFFFF_FFFF_FFFF_FFFB, 64'd77, 64'd9, 1'b1, 1'b1, 64'h0000_0005_0000_0005, 1'b1, 1'b0, 4'd1};
        vecs[10] = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0, 4'd1};
        vecs[11] = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd9, 1'b0, 1'b1, 4'd1};
        vecs[12] = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0};
        vecs[13] = '{1'b1, 3'b010, 64'd0, 64'd42, 64'd0, 1'b1, 1'b1, 64'h0000_0002_0000_0006, 1'b1, 1'b0, 4'd1};
        vecs[14] = '{1'b1, 3'b001, 64'd11, 64'd0, 64'd0, 1'b1, 1'b1, 64'd42, 1'b0, 1'b1, 4'd2};
        vecs[15] = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'h0000_0001_0000_0007, 1'b1, 1'b0, 4'd1};
        vecs[16] = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd11, 1'b0, 1'b1, 4'd1};
        vecs[17] = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0};
        vecs[18] = '{1'b1, 3'b100, 64'd0, 64'd0, 64'd5, 1'b1, 1'b1, 64'h0000_0004_0000_0008, 1'b1, 1'b0, 4'd1};
        vecs[19] = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd5, 1'b0, 1'b1, 4'd1};
        vecs[20] = '{1'b1, 3'b001, 64'd99, 64'd0, 64'd0, 1'b1, 1'b1, 64'h0000_0001_0000_0009, 1'b1, 1'b0, 4'd1};
        vecs[21] = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd99, 1'b0, 1'b1, 4'd1};
        vecs[22] = '{1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 4'd0};

        // Reset state, then release away from the clock edge.
        #12;
        chk_reset_state("reset");
        rst = 1'b1;
        tick();

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].en, vecs[i].act, vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].rdy);
            tick();
            chk($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d.level", i), 64'(fifo_level), 64'(vecs[i].elv));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d.data", i),  out_data, vecs[i].ed);
                chk($sformatf("vec%0d.first", i), 64'(out_first), 64'(vecs[i].ef));
                chk($sformatf("vec%0d.last", i),  64'(out_last), 64'(vecs[i].el));
            end
        end

        // Backpressure: header stalled for 10 cycles, then the words flow unchanged.
        drive(1'b1, 3'b011, 64'd100, 64'd200, 64'd0, 1'b0);
        tick();
        chk_word("bp.hdr", hdr(3'b011, 32'd10), 1'b1, 1'b0);
        drive(1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_word($sformatf("bp.stall%0d", i), hdr(3'b011, 32'd10), 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk_word("bp.v0", 64'd100, 1'b0, 1'b0);
        tick();
        chk_word("bp.v1", 64'd200, 1'b0, 1'b1);
        tick();
        chk("bp.idle", 64'(out_valid), 64'd0);
        chk("bp.level", 64'(fifo_level), 64'd0);

        // Overflow: 10 single-stream captures with no draining.
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'b001, 64'(i), 64'd0, 64'd0, 1'b0);
            tick();
            chk($sformatf("ovf%0d.level", i), 64'(fifo_level), (i < 8) ? 64'(i + 1) : 64'd8);
            chk($sformatf("ovf%0d.drops", i), 64'(drop_count), (i < 8) ? 64'd0 : 64'(i - 7));
            chk($sformatf("ovf%0d.flag", i),  64'(overflow), (i < 8) ? 64'd0 : 64'd1);
            chk_word($sformatf("ovf%0d.hdr", i), hdr(3'b001, 32'd0), 1'b1, 1'b0);
        end

        // Push and pop at full on the final word of the first record.
        drive(1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1);
        tick();
        chk_word("full.v0", 64'd0, 1'b0, 1'b1);
        drive(1'b1, 3'b010, 64'd0, 64'd555, 64'd0, 1'b1);
        tick();
        chk("full.level", 64'(fifo_level), 64'd8);
        chk("full.drops", 64'(drop_count), 64'd2);
        drive(1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1);
        for (int k = 1; k < 8; k++) begin
            chk_word($sformatf("drain%0d.hdr", k), hdr(3'b001, 32'(k)), 1'b1, 1'b0);
            chk($sformatf("drain%0d.level", k), 64'(fifo_level), 64'(9 - k));
            tick();
            chk_word($sformatf("drain%0d.val", k), 64'(k), 1'b0, 1'b1);
            tick();
        end
        chk_word("late.hdr", hdr(3'b010, 32'd10), 1'b1, 1'b0);
        tick();
        chk_word("late.val", 64'd555, 1'b0, 1'b1);
        tick();
        chk("late.idle", 64'(out_valid), 64'd0);
        chk("late.level", 64'(fifo_level), 64'd0);
        chk("late.drops", 64'(drop_count), 64'd2);
        chk("late.ovf", 64'(overflow), 64'd1);

        // Reset in the middle of a 3-stream record.
        drive(1'b1, 3'b111, 64'd7, 64'd8, 64'd9, 1'b1);
        tick();
        chk_word("mid.hdr", hdr(3'b111, 32'd11), 1'b1, 1'b0);
        drive(1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1);
        tick();
        chk_word("mid.v0", 64'd7, 1'b0, 1'b0);
        tick();
        chk_word("mid.v1", 64'd8, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_state("midrst");
        #1;
        rst = 1'b1;
        drive(1'b1, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post%0d.valid", i), 64'(out_valid), 64'd0);
        end
        drive(1'b1, 3'b001, 64'd123, 64'd0, 64'd0, 1'b1);
        tick();
        chk_word("post.hdr", hdr(3'b001, 32'd3), 1'b1, 1'b0);
        drive(1'b0, 3'b000, 64'd0, 64'd0, 64'd0, 1'b1);
        tick();
        chk_word("post.val", 64'd123, 1'b0, 1'b1);
        tick();
        chk("post.idle", 64'(out_valid), 64'd0);
        chk("post.level", 64'(fifo_level), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
